disp_scroller: RTL and testbench

DISP_SCROLLER -- requirements
Module: disp_scroller

---
 rtl/disp_scroller_if.sv | 30 +++
 rtl/disp_scroller.sv | 164 ++++++++++++++++
 tb/tb_disp_scroller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/disp_scroller_if.sv
// disp_scroller_if: host-side bus of the scrolling display controller.
//   wr_en/wr_data/wr_ready : one-symbol write handshake into the message buffer
//   start/stop/clear       : single-cycle control pulses
//   msg_len                : stored symbol count (0..16)
//   disps                  : {RUN, PAUSE, four 5-bit digit codes, leftmost first}
// Modports: master drives writes/controls, slave is the scroller.
interface disp_scroller_if;
    localparam int unsigned SYM_W  = 5;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned DISP_W = 22;

    logic              wr_en;
    logic [SYM_W-1:0]  wr_data;
    logic              wr_ready;
    logic              start;
    logic              stop;
    logic              clear;
    logic [LEN_W-1:0]  msg_len;
    logic [DISP_W-1:0] disps;

    modport master (
        output wr_en, wr_data, start, stop, clear,
        input  wr_ready, msg_len, disps
    );

    modport slave (
        input  wr_en, wr_data, start, stop, clear,
        output wr_ready, msg_len, disps
    );
endinterface

// File: rtl/disp_scroller.sv
// disp_scroller: 16-symbol message buffer scrolled through a 4-digit window.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : disp_scroller_if.slave (writes, start/stop/clear, msg_len, disps)
// The scroll sequence is the message followed by four BLANK_CODE symbols;
// the window advances one symbol every STEP_CYCLES clocks while running.
// Optional feature: define PAUSE_BLINK_EN to blink the frozen window between
// the symbols and all-blank every STEP_CYCLES clocks while paused.
module disp_scroller #(
    parameter int unsigned STEP_CYCLES = 25000000,
    parameter logic [4:0]  BLANK_CODE  = 5'h1F
) (
    input  logic           clk,
    input  logic           reset,
    disp_scroller_if.slave bus
);
    localparam int unsigned SYM_W  = 5;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned POS_W  = 5;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
    localparam logic [LEN_W-1:0]      LEN_FULL  = LEN_W'(DEPTH);
    localparam logic [NDIG*SYM_W-1:0] BLANK_WIN = {NDIG{BLANK_CODE}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                  state;
    logic [LEN_W-1:0]        msg_len_q;
    logic [POS_W-1:0]        pos_q;
    logic [PRE_W-1:0]        presc_q;
    logic                    wr_ready_q;
    logic [21:0]             disps_q;
    logic [SYM_W-1:0]        buf_q [DEPTH];

    logic                    wr_fire_c;
    logic [POS_W-1:0]        last_pos_c;
    logic [IDX_W-1:0]        seq_len_c;
    logic [IDX_W-1:0]        idx_c;
    logic [SYM_W-1:0]        win_c [NDIG];
    logic [NDIG*SYM_W-1:0]   window_c;
    logic [NDIG*SYM_W-1:0]   shown_c;

    // A write only lands in IDLE when no higher-priority control is active.
    assign wr_fire_c = bus.wr_en && wr_ready_q && (state == ST_IDLE) &&
                       !bus.clear && !bus.stop &&
                       !(bus.start && (msg_len_q != '0));

    assign last_pos_c = POS_W'(msg_len_q) + POS_W'(3);

    // Buffer storage; contents are never shown beyond msg_len, so no reset.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            buf_q[msg_len_q[3:0]] <= bus.wr_data;
        end
    end

    // Control FSM with position and prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            msg_len_q  <= '0;
            pos_q      <= '0;
            presc_q    <= '0;
            wr_ready_q <= 1'b1;
        end else if (bus.clear) begin
            state      <= ST_IDLE;
            msg_len_q  <= '0;
            pos_q      <= '0;
            presc_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.stop && bus.start && (msg_len_q != '0)) begin
                        state      <= ST_RUN;
                        pos_q      <= '0;
                        presc_q    <= '0;
                        wr_ready_q <= 1'b0;
                    end else if (wr_fire_c) begin
                        msg_len_q  <= msg_len_q + LEN_W'(1);
                        wr_ready_q <= (msg_len_q != LEN_FULL - LEN_W'(1));
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state <= ST_PAUSE;
                    end else if (presc_q == PRE_LAST) begin
                        presc_q <= '0;
                        pos_q   <= (pos_q == last_pos_c) ? '0 : pos_q + POS_W'(1);
                    end else begin
                        presc_q <= presc_q + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Window symbols: sequence index wraps at msg_len+4, blanks past the message.
    always_comb begin
        seq_len_c = IDX_W'(msg_len_q) + IDX_W'(4);
        idx_c     = '0;
        for (int k = 0; k < NDIG; k++) begin
            idx_c = IDX_W'(pos_q) + IDX_W'(k);
            if (idx_c >= seq_len_c) begin
                idx_c = idx_c - seq_len_c;
            end
            win_c[k] = (idx_c < IDX_W'(msg_len_q)) ? buf_q[idx_c[3:0]] : BLANK_CODE;
        end
        window_c = {win_c[0], win_c[1], win_c[2], win_c[3]};
    end

`ifdef PAUSE_BLINK_EN
    logic [PRE_W-1:0] blink_cnt_q;
    logic             blink_off_q;

    // Blink phase restarts on the window whenever PAUSE is (re)entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (state != ST_PAUSE) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (blink_cnt_q == PRE_LAST) begin
            blink_cnt_q <= '0;
            blink_off_q <= ~blink_off_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + PRE_W'(1);
        end
    end

    assign shown_c = blink_off_q ? BLANK_WIN : window_c;
`else
    assign shown_c = window_c;
`endif

    // Display register: one clock behind state/pos/buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disps_q <= {2'b00, BLANK_WIN};
        end else begin
            disps_q <= {(state == ST_RUN), (state == ST_PAUSE), shown_c};
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.msg_len  = msg_len_q;
    assign bus.disps    = disps_q;
endmodule

// File: tb/tb_disp_scroller.sv
// tb_disp_scroller: directed and random checks of disp_scroller (STEP_CYCLES=4)
// against a message-queue model where position = (run ticks / STEP) mod (len+4).
module tb_disp_scroller;
    localparam int unsigned STEP  = 4;
    localparam logic [4:0]  BLANK = 5'h1F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disp_scroller_if bus();

    disp_scroller #(
        .STEP_CYCLES(STEP),
        .BLANK_CODE (BLANK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = pause.
    logic [4:0] m_msg[$];
    int         m_mode  = 0;
    int         m_ticks = 0;

    function automatic logic [21:0] model_disps();
        int         len = m_msg.size();
        int         L   = len + 4;
        int         pos = (m_mode == 0) ? 0 : (m_ticks / STEP) % L;
        logic [21:0] d;
        d[21] = (m_mode == 1);
        d[20] = (m_mode == 2);
        for (int k = 0; k < 4; k++) begin
            int         i = (pos + k) % L;
            logic [4:0] s = (i < len) ? m_msg[i] : BLANK;
            d[19-5*k -: 5] = s;
        end
        return d;
    endfunction

    task automatic model_step(input bit we, input logic [4:0] wd,
                              input bit st, input bit sp, input bit cl);
        if (cl) begin
            m_msg.delete();
            m_mode  = 0;
            m_ticks = 0;
        end else if (sp) begin
            if (m_mode == 1) m_mode = 2;
        end else if (st && m_mode == 0 && m_msg.size() > 0) begin
            m_mode  = 1;
            m_ticks = 0;
        end else if (st && m_mode == 2) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_ticks++;
        end else if (m_mode == 0 && we && m_msg.size() < 16) begin
            m_msg.push_back(wd);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, advance model, compare all outputs.
    task automatic cyc(input bit we, input logic [4:0] wd,
                       input bit st, input bit sp, input bit cl);
        logic [21:0] exp_d;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.start   = st;
        bus.stop    = sp;
        bus.clear   = cl;
        exp_d = model_disps();
        @(posedge clk);
        #1;
        model_step(we, wd, st, sp, cl);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        check("disps",    32'(bus.disps),    32'(exp_d));
        check("msg_len",  32'(bus.msg_len),  32'(m_msg.size()));
        check("wr_ready", 32'(bus.wr_ready), 32'((m_mode == 0) && (m_msg.size() < 16)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 5'h0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.clear   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_disps",    32'(bus.disps),    32'h0FFFFF);
        check("rst_msg_len",  32'(bus.msg_len),  32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        reset = 1'b1;

        // Load 1..5 and view the static window.
        for (int v = 1; v <= 5; v++) cyc(1'b1, 5'(v), 1'b0, 1'b0, 1'b0);
        check("len5", 32'(bus.msg_len), 32'd5);
        idle(1);
        check("idle_win", 32'(bus.disps[19:0]), 32'h08864);

        // Scroll, with literal windows at the step points.
        cyc(1'b0, 5'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("run_flag", 32'(bus.disps[21]), 32'd1);
        idle(4);
        check("win_pos1", 32'(bus.disps[19:0]), 32'h10C85);
        idle(4);
        check("win_pos2", 32'(bus.disps[19:0]), 32'h190BF);
        idle(28);
        check("win_wrap", 32'(bus.disps[19:0]), 32'h08864);

        // Pause at pos 2 mid-prescale, then resume.
        idle(9);
        cyc(1'b0, 5'h0, 1'b0, 1'b1, 1'b0);
        idle(6);
        check("paused", 32'(bus.disps), 32'h1190BF);
        cyc(1'b0, 5'h0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("resume_hold", 32'(bus.disps), 32'h2190BF);
        idle(1);
        check("resume_step", 32'(bus.disps), 32'h2217FF);

        // start+stop together while running lands in PAUSE.
        cyc(1'b0, 5'h0, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("startstop", 32'(bus.disps[21:20]), 32'd1);

        // Asynchronous reset in the middle of RUN.
        cyc(1'b0, 5'h0, 1'b1, 1'b0, 1'b0);
        idle(3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_disps",    32'(bus.disps),    32'h0FFFFF);
        check("arst_msg_len",  32'(bus.msg_len),  32'd0);
        check("arst_wr_ready", 32'(bus.wr_ready), 32'd1);
        m_msg.delete();
        m_mode  = 0;
        m_ticks = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // start with an empty buffer is ignored.
        cyc(1'b0, 5'h0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Fill to 16, then a 17th write must be dropped.
        for (int i = 0; i < 16; i++) cyc(1'b1, 5'($urandom_range(0, 30)), 1'b0, 1'b0, 1'b0);
        check("full_len",   32'(bus.msg_len),  32'd16);
        check("full_ready", 32'(bus.wr_ready), 32'd0);
        cyc(1'b1, 5'h1E, 1'b0, 1'b0, 1'b0);
        check("over_len", 32'(bus.msg_len), 32'd16);
        cyc(1'b0, 5'h0, 1'b1, 1'b0, 1'b0);
        idle(84);

        // clear with a simultaneous write during RUN.
        cyc(1'b1, 5'h07, 1'b0, 1'b0, 1'b1);
        check("clr_len", 32'(bus.msg_len), 32'd0);
        idle(1);
        check("clr_disps", 32'(bus.disps), 32'h0FFFFF);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
